kmac_encode_stream: RTL and testbench
=====================================

Name: kmac_encode_stream

Overview:
Sequential NIST SP 800-185 integer encoder for the KMAC datapath. It implements right_encode(x) and left_encode(x) and sits directly upstream of the KMAC right-pad stage. It emits the encoded byte string (the enc8 sequence) one byte per transfer over a valid/ready stream. The pad stage and the absorb buffer capture these bytes.

Parameters:
VAL_W, 64, width of the integer to encode; multiple of 8, range 8..64.
NB_W, $clog2(VAL_W/8+2), width of the byte-count output.

Ports:
clk        input   1        clock; all logic on rising edge
rst        input   1        asynchronous, active-high reset
start      input   1        request an encode; sampled only in IDLE
mode       input   1        0 = right_encode (x bytes then n), 1 = left_encode (n then x bytes)
value      input   VAL_W    integer x to encode; sampled with start
busy       output  1        high from the cycle after start is accepted until done is asserted
out_valid  output  1        out_byte is valid
out_ready  input   1        downstream accepts the byte when out_valid && out_ready
out_byte   output  8        encoded byte
out_last   output  1        marks the final byte of the encoding; qualified by out_valid
enc_len    output  NB_W     total encoded length n+1 in bytes; valid while busy
done       output  1        one-cycle pulse after the last byte transfers

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; busy, out_valid, out_last and done are 0; out_byte=0; enc_len=0; internal registers cleared. Reset wins over all other inputs, including in the middle of an encode; any partial stream is dropped with no done pulse.
- States: IDLE -> CALC -> EMIT -> DONE -> IDLE.
- IDLE:
  - When start=1, latch value and mode, then go to CALC.
  - start is ignored in every other state. Inputs are not re-sampled.
- CALC (1 cycle):
  - n = index of the most significant nonzero byte of the latched x, plus 1.
  - x=0 gives n=1, so the single value byte is 0x00.
  - enc_len = n+1. Initialise the byte index. Go to EMIT.
- EMIT:
  - out_valid=1. One byte is sent per handshake.
  - right_encode order: x bytes, most significant first (byte n-1 down to byte 0), then the byte n.
  - left_encode order: the byte n first, then x bytes, most significant first.
  - out_byte and out_last hold stable while out_valid && !out_ready.
  - out_last=1 only on byte index enc_len-1.
  - When the last byte transfers, go to DONE. out_valid falls in the following cycle.
- DONE (1 cycle): done=1, busy=0, out_valid=0. Next state is IDLE. A start in this cycle is ignored. A new start is accepted from IDLE on the next cycle.
- Latency with out_ready held high:
  - start sampled at edge k.
  - CALC during cycle k+1.
  - First out_valid in cycle k+2.
  - Last byte in cycle k+1+enc_len.
  - done in cycle k+2+enc_len.
- Width rules:
  - n ranges 1..VAL_W/8 and always fits in one byte.
  - The byte index counter is NB_W bits and must never wrap within an encode.
- busy is 1 in CALC and EMIT, and 0 in IDLE and DONE.

Test Plan:
- mode=0, value=0, out_ready=1 -> out_byte 0x00 then 0x01 (last); enc_len=2; done pulses in cycle k+4.
- mode=0, value=256 -> 0x01, 0x00, 0x02 (last); enc_len=3.
- mode=1, value=136 -> 0x01, 0x88 (last). mode=1, value=0x1234 -> 0x02, 0x12, 0x34.
- mode=0, value=64'hFFFF_FFFF_FFFF_FFFF -> eight 0xFF bytes then 0x08 (last); enc_len=9, with no wrap of the counter.
- Backpressure: mode=0, value=0x0100, out_ready toggled 0/1 every cycle -> bytes held stable while stalled; exact sequence 0x01, 0x00, 0x02; exactly one done pulse. A start asserted while busy is ignored.
- Assert rst during EMIT after the first byte -> out_valid, busy and done drop to 0 immediately; the next start restarts cleanly from the first byte.

Source files
------------

// File: rtl/kmac_encode_stream.sv
// kmac_encode_stream: streams right_encode/left_encode(x) one byte per valid/ready handshake.
module kmac_encode_stream #(
  parameter int VAL_W = 64,
  parameter int NB_W  = $clog2(VAL_W/8+2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [VAL_W-1:0] value,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic [NB_W-1:0]  enc_len,
  output logic             done
);
  localparam int NB = VAL_W/8;
  typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic mode_q, mode_d, busy_q, busy_d, out_valid_q, out_valid_d, out_last_q, out_last_d, done_q, done_d;
  logic [7:0] out_byte_q, out_byte_d;
  logic [NB_W-1:0] idx_q, idx_d, enc_len_q, enc_len_d, n_calc, n_cur, nxt;
  // Byte at stream position i: the length byte sits first (left) or last (right).
  function automatic logic [7:0] sel_byte(input logic [VAL_W-1:0] x, input logic m,
                                          input logic [NB_W-1:0] n, input logic [NB_W-1:0] i);
    logic [VAL_W-1:0] s;
    s = x >> {(m ? n - i : n - NB_W'(1) - i), 3'b000};
    return (m ? i == '0 : i == n) ? 8'(n) : s[7:0];
  endfunction
  always_comb begin
    n_calc = NB_W'(1);
    for (int i = 1; i < NB; i++) if (val_q[8*i +: 8] != 8'd0) n_calc = NB_W'(i + 1);
    n_cur = enc_len_q - NB_W'(1);
    nxt = idx_q + NB_W'(1);
    state_d = state_q;
    val_d = val_q;
    mode_d = mode_q;
    idx_d = idx_q;
    enc_len_d = enc_len_q;
    busy_d = busy_q;
    out_valid_d = out_valid_q;
    out_byte_d = out_byte_q;
    out_last_d = out_last_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        val_d = value;
        mode_d = mode;
        busy_d = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        enc_len_d = n_calc + NB_W'(1);
        idx_d = '0;
        out_valid_d = 1'b1;
        out_byte_d = sel_byte(val_q, mode_q, n_calc, '0);
        out_last_d = 1'b0;
        state_d = EMIT;
      end
      EMIT: if (out_ready) begin
        if (out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = nxt;
          out_byte_d = sel_byte(val_q, mode_q, n_cur, nxt);
          out_last_d = nxt == n_cur;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      val_q <= '0;
      mode_q <= 1'b0;
      idx_q <= '0;
      enc_len_q <= '0;
      busy_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q <= 8'd0;
      out_last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q <= val_d;
      mode_q <= mode_d;
      idx_q <= idx_d;
      enc_len_q <= enc_len_d;
      busy_q <= busy_d;
      out_valid_q <= out_valid_d;
      out_byte_q <= out_byte_d;
      out_last_q <= out_last_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign out_valid = out_valid_q;
  assign out_byte = out_byte_q;
  assign out_last = out_last_q;
  assign enc_len = enc_len_q;
  assign done = done_q;
endmodule

// File: tb/tb_kmac_encode_stream.sv
// tb_kmac_encode_stream: table vectors, randomized encodes against a queue model, reset corners.
module tb_kmac_encode_stream;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic [63:0] value = '0;
  logic busy, out_valid, out_last, done;
  logic [7:0] out_byte;
  logic [3:0] enc_len;
  int pass_cnt = 0, total_cnt = 0;
  logic [7:0] exp_q[$], got_q[$];
  typedef struct {
    logic m;
    logic [63:0] v;
    int rm;
    int len;
    logic [0:8][7:0] b;
  } vec_t;
  vec_t tbl[6];

  kmac_encode_stream #(.VAL_W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .value(value), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
    .enc_len(enc_len), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total_cnt++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", nm, a, e);
    else pass_cnt++;
  endtask

  // Minimal big-endian byte string of x, with the byte count placed per mode.
  task automatic model(input logic m, input logic [63:0] v);
    logic [7:0] xb[$];
    logic [63:0] x;
    x = v;
    do begin
      xb.push_front(x[7:0]);
      x = x >> 8;
    end while (x != 0);
    exp_q = m ? {8'(xb.size()), xb} : {xb, 8'(xb.size())};
  endtask

  task automatic run(input logic m, input logic [63:0] v, input int rm);
    int t, len;
    bit stall;
    logic [7:0] pb;
    logic pl;
    model(m, v);
    len = exp_q.size();
    got_q.delete();
    stall = 0;
    pb = '0;
    pl = 1'b0;
    @(negedge clk);
    start = 1'b1;
    mode = m;
    value = v;
    @(negedge clk);
    if (rm == 1) begin
      value = ~v;
      mode = ~m;
    end else start = 1'b0;
    t = 1;
    chk("calc_busy", busy, 1);
    chk("calc_valid", out_valid, 0);
    while (t < 400) begin
      @(negedge clk);
      t++;
      out_ready = rm == 0 ? 1'b1 : rm == 1 ? t[0] : 1'($urandom_range(0, 1));
      if (out_valid) begin
        if (stall) begin
          chk("hold_byte", out_byte, pb);
          chk("hold_last", out_last, pl);
        end
        chk("enc_len", enc_len, len);
        chk("emit_busy", busy, 1);
        if (out_ready) begin
          got_q.push_back(out_byte);
          chk("last_flag", out_last, got_q.size() == len);
          if (out_last) begin
            start = 1'b0;
            break;
          end
        end
        stall = !out_ready;
        pb = out_byte;
        pl = out_last;
      end
    end
    if (t >= 400) chk("timeout", 0, 1);
    @(negedge clk);
    t++;
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", out_valid, 0);
    if (rm == 0) chk("done_cycle", t, len + 2);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("stream_len", got_q.size(), len);
    for (int i = 0; i < len && i < got_q.size(); i++) chk("stream_byte", got_q[i], exp_q[i]);
  endtask

  initial begin
    tbl[0] = '{1'b0, 64'd0, 0, 2, {8'h00, 8'h01, 56'd0}};
    tbl[1] = '{1'b0, 64'd256, 0, 3, {8'h01, 8'h00, 8'h02, 48'd0}};
    tbl[2] = '{1'b1, 64'd136, 0, 2, {8'h01, 8'h88, 56'd0}};
    tbl[3] = '{1'b1, 64'h1234, 0, 3, {8'h02, 8'h12, 8'h34, 48'd0}};
    tbl[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 9, {{8{8'hFF}}, 8'h08}};
    tbl[5] = '{1'b0, 64'h0100, 1, 3, {8'h01, 8'h00, 8'h02, 48'd0}};
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_len", enc_len, 0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      run(tbl[k].m, tbl[k].v, tbl[k].rm);
      chk("tbl_len", got_q.size(), tbl[k].len);
      for (int i = 0; i < tbl[k].len && i < got_q.size(); i++) chk("tbl_byte", got_q[i], tbl[k].b[i]);
    end
    for (int k = 0; k < 30; k++) begin
      logic [63:0] rv;
      rv = {$urandom, $urandom} >> (8 * $urandom_range(0, 8));
      run(1'($urandom_range(0, 1)), rv, 2);
    end
    // Reset in the middle of an encode, after the first byte transfers.
    @(negedge clk);
    out_ready = 1'b1;
    start = 1'b1;
    mode = 1'b1;
    value = 64'h1234;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    chk("mid_valid", out_valid, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_done", done, 0);
    run(1'b1, 64'h1234, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
